memory_stage: RTL and testbench
===============================

# memory_stage

Data-memory stage of the Y86-64 sequential core, sitting between execute and write-back. It consumes `valE`/`valA`/`valP` and produces `valM` for the register file's write-back port. Stack and move instructions use a start/done handshake with a configurable access latency. Storage is a word-addressed 64-bit data memory.

## Interface
- `MEM_WORDS`, default 256: number of 64-bit words in data memory; power of two.
- `LATENCY`, default 2: cycles spent in BUSY per access; must be ≥1.
- `clk` in 1: clock; all state updates on posedge.
- `reset` in 1: synchronous, active-high reset.
- `start` in 1: request; sampled only while `ready`=1.
- `icode` in 4: instruction code, using Y86 encoding.
- `valE` in 64 (signed): ALU result; the address for rmmovq, mrmovq, call and pushq.
- `valA` in 64 (signed): store data for rmmovq and pushq; the address for ret and popq.
- `valP` in 64: return address, stored by call.
- `ready` out 1: high in IDLE.
- `done` out 1: one-cycle completion pulse.
- `valM` out 64 (signed): read data.
- `dmem_error` out 1: address fault, valid with `done`.

## Operation
- Access table, by `icode`:
  - 4 rmmovq: M[valE] ← valA.
  - 5 mrmovq: valM ← M[valE].
  - 8 call: M[valE] ← valP.
  - 9 ret: valM ← M[valA].
  - A pushq: M[valE] ← valA.
  - B popq: valM ← M[valA].
  - All other icodes: no access, but the full handshake still runs.
- Addressing: byte address; word index = addr >> 3. With `MEM_ERR_CHECK_EN` undefined, low 3 bits are ignored and the index wraps modulo `MEM_WORDS`.
- On `start` accepted, latch `icode`, address, and store data (valA or valP); later input changes have no effect.
- FSM:
  - IDLE: `ready`=1. Goes to BUSY on `start`, loading counter = LATENCY-1.
  - BUSY: decrement the counter. At the edge where the counter is 0, commit the write or capture the read, then go to DONE.
  - DONE: `done`=1 for exactly one cycle, then return to IDLE.
- `valM` updates only on a completed read. It holds its value across write and no-access operations.
- Memory contents are zero at time 0 and are not cleared by `reset`.

## Timing
- `start` sampled at edge 0 → access committed at edge LATENCY → `done` high during the cycle after edge LATENCY.
- `ready` returns at edge LATENCY+1. Back-to-back throughput is one op per LATENCY+2 cycles.
- `start` while `ready`=0 is ignored; it is neither queued nor a protocol error.
- Reset values: state IDLE, `ready`=1, `done`=0, `valM`=0, `dmem_error`=0, counter 0.
- Reset while in BUSY aborts the operation. No write is committed if `reset` is high at the commit edge, and `done` does not pulse.
- Read-after-write on the next operation returns the new data; there is no bypass hazard, because commit precedes DONE.
- `dmem_error` is cleared when a new `start` is accepted and holds its value until then.

## Configuration
- `MEM_ERR_CHECK_EN` defined:
  - A misaligned address (addr[2:0]≠0) or an index ≥ `MEM_WORDS` sets `dmem_error`=1 with `done`.
  - The write is suppressed, and a faulting read drives `valM`=0.
  - Negative addresses fault.
- `MEM_ERR_CHECK_EN` undefined:
  - `dmem_error` is tied to 0.
  - Addresses wrap as described in Operation.

## Structure
- Shared package `y86_pkg` holds:
  - `ICODE_*` constants (HALT..POPQ).
  - `WORD_W`=64.
  - The FSM state enum.
- Sub-module `dmem_array`: single-port synchronous RAM with `MEM_WORDS`×64, write enable, and registered read data.

## Test plan
Defaults apply: MEM_WORDS=256, LATENCY=2.
- After reset: `ready`=1, `done`=0, `valM`=0. Then pushq with valE=0x100, valA=0x2A, followed by popq with valA=0x100 → `valM`=0x2A; `done` asserted 3 cycles after each accepted `start`.
- rmmovq with valE=0x08, valA=-5, then mrmovq with valE=0x08 → `valM`=0xFFFF_FFFF_FFFF_FFFB. Then call with valE=0x10, valP=0x40, followed by ret with valA=0x10 → `valM`=0x40.
- `start` pulsed during BUSY with a different icode → ignored: exactly one `done`, and memory is unchanged by the second request.
- mrmovq with valE=0x800 (index 256):
  - With `MEM_ERR_CHECK_EN`: `dmem_error`=1 and `valM`=0.
  - Without it: reads index 0 and `dmem_error`=0.
- `reset` asserted at the cycle after `start` of rmmovq with valE=0x20, valA=7 → no `done`, and a later mrmovq of 0x20 returns 0.
- nop (icode 1) → `done` after 3 cycles, with no memory access and `valM` unchanged.

Source files
------------

// File: rtl/y86_pkg.sv
// Shared Y86-64 definitions: instruction codes, datapath width, memory-stage FSM states
// and the per-icode access decode used by the data-memory stage.
package y86_pkg;

    localparam int WORD_W = 64;

    localparam logic [3:0] ICODE_HALT   = 4'h0;
    localparam logic [3:0] ICODE_NOP    = 4'h1;
    localparam logic [3:0] ICODE_RRMOVQ = 4'h2;
    localparam logic [3:0] ICODE_IRMOVQ = 4'h3;
    localparam logic [3:0] ICODE_RMMOVQ = 4'h4;
    localparam logic [3:0] ICODE_MRMOVQ = 4'h5;
    localparam logic [3:0] ICODE_OPQ    = 4'h6;
    localparam logic [3:0] ICODE_JXX    = 4'h7;
    localparam logic [3:0] ICODE_CALL   = 4'h8;
    localparam logic [3:0] ICODE_RET    = 4'h9;
    localparam logic [3:0] ICODE_PUSHQ  = 4'hA;
    localparam logic [3:0] ICODE_POPQ   = 4'hB;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } mem_state_t;

    function automatic logic is_mem_write(input logic [3:0] ic);
        return (ic == ICODE_RMMOVQ) || (ic == ICODE_CALL) || (ic == ICODE_PUSHQ);
    endfunction

    function automatic logic is_mem_read(input logic [3:0] ic);
        return (ic == ICODE_MRMOVQ) || (ic == ICODE_RET) || (ic == ICODE_POPQ);
    endfunction

    // ret/popq address through the old stack pointer carried on valA
    function automatic logic addr_from_vala(input logic [3:0] ic);
        return (ic == ICODE_RET) || (ic == ICODE_POPQ);
    endfunction

    function automatic logic store_from_valp(input logic [3:0] ic);
        return ic == ICODE_CALL;
    endfunction

endpackage

// File: rtl/dmem_array.sv
// Single-port synchronous data RAM, MEM_WORDS x 64, read-before-write.
// Latency: read data registered, valid the cycle after the address is presented.
// Backpressure: none; accepts an access every cycle.
module dmem_array
    import y86_pkg::*;
#(
    parameter int MEM_WORDS = 256,
    parameter int IDX_W     = $clog2(MEM_WORDS)
) (
    input  logic              clk,
    input  logic              we,
    input  logic [IDX_W-1:0]  addr,
    input  logic [WORD_W-1:0] wdata,
    output logic [WORD_W-1:0] rdata
);

    logic [WORD_W-1:0] r_mem [MEM_WORDS];
    logic [WORD_W-1:0] r_rdata;

    always_ff @(posedge clk) begin
        if (we) begin
            r_mem[addr] <= wdata;
        end
        r_rdata <= r_mem[addr];
    end

    assign rdata = r_rdata;

endmodule

// File: rtl/memory_stage.sv
// Y86-64 data-memory stage; optional address fault checking under MEM_ERR_CHECK_EN.
// Latency: access commits LATENCY edges after start is accepted, done pulses the following cycle.
// Backpressure: ready low from accept until after done; start while not ready is dropped.
module memory_stage
    import y86_pkg::*;
#(
    parameter int MEM_WORDS = 256,
    parameter int LATENCY   = 2
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     start,
    input  logic [3:0]               icode,
    input  logic signed [WORD_W-1:0] valE,
    input  logic signed [WORD_W-1:0] valA,
    input  logic [WORD_W-1:0]        valP,
    output logic                     ready,
    output logic                     done,
    output logic signed [WORD_W-1:0] valM,
    output logic                     dmem_error
);

    localparam int IDX_W = $clog2(MEM_WORDS);
    localparam int CNT_W = (LATENCY > 1) ? $clog2(LATENCY) : 1;
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(LATENCY - 1);

    mem_state_t         r_state;
    logic [CNT_W-1:0]   r_cnt;
    logic [3:0]         r_icode;
    logic [IDX_W-1:0]   r_idx;
    logic [WORD_W-1:0]  r_wdata;
    logic               r_fault;
    logic [WORD_W-1:0]  r_valm;

    logic [WORD_W-1:0]  w_addr;
    logic [WORD_W-1:0]  w_store;
    logic [WORD_W-1:0]  w_rdata;
    logic [IDX_W-1:0]   w_idx;
    logic [IDX_W-1:0]   w_ram_idx;
    logic               w_accept;
    logic               w_commit;
    logic               w_we;
    logic               w_fault;

    assign w_addr   = addr_from_vala(icode) ? valA : valE;
    assign w_store  = store_from_valp(icode) ? valP : valA;
    assign w_idx    = IDX_W'(w_addr >> 3);
    assign w_accept = (r_state == ST_IDLE) && start;
    assign w_commit = (r_state == ST_BUSY) && (r_cnt == '0);
    assign w_we     = w_commit && is_mem_write(r_icode) && !r_fault && !reset;

    // Idle: look up the incoming address so read data is already registered by
    // the commit edge even when LATENCY is 1.
    assign w_ram_idx = (r_state == ST_IDLE) ? w_idx : r_idx;

`ifdef MEM_ERR_CHECK_EN
    // Negative addresses carry bit 63 and so fail the upper-bits test as well.
    assign w_fault = (is_mem_write(icode) || is_mem_read(icode)) &&
                     ((w_addr[2:0] != 3'b000) || ((w_addr >> (IDX_W + 3)) != '0));
`else
    assign w_fault = 1'b0;
`endif

    dmem_array #(
        .MEM_WORDS (MEM_WORDS),
        .IDX_W     (IDX_W)
    ) u_dmem (
        .clk   (clk),
        .we    (w_we),
        .addr  (w_ram_idx),
        .wdata (r_wdata),
        .rdata (w_rdata)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
            r_icode <= ICODE_NOP;
            r_idx   <= '0;
            r_wdata <= '0;
            r_fault <= 1'b0;
            r_valm  <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        r_state <= ST_BUSY;
                        r_cnt   <= CNT_LOAD;
                        r_icode <= icode;
                        r_idx   <= w_idx;
                        r_wdata <= w_store;
                        r_fault <= w_fault;
                    end
                end
                ST_BUSY: begin
                    if (r_cnt == '0) begin
                        r_state <= ST_DONE;
                        if (is_mem_read(r_icode)) begin
                            r_valm <= r_fault ? '0 : w_rdata;
                        end
                    end else begin
                        r_cnt <= r_cnt - 1'b1;
                    end
                end
                ST_DONE: r_state <= ST_IDLE;
                default: r_state <= ST_IDLE;
            endcase
        end
    end

`ifdef MEM_ERR_CHECK_EN
    logic r_err;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_err <= 1'b0;
        end else if (w_accept) begin
            r_err <= 1'b0;
        end else if (w_commit) begin
            r_err <= r_fault;
        end
    end

    assign dmem_error = r_err;
`else
    assign dmem_error = 1'b0;
`endif

    assign ready = (r_state == ST_IDLE);
    assign done  = (r_state == ST_DONE);
    assign valM  = r_valm;

endmodule

// File: tb/tb_memory_stage.sv
// Self-checking bench for memory_stage: edge-count reference model plus directed literal checks.
module tb_memory_stage;

    localparam int LAT   = 2;
    localparam int WORDS = 256;

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic              start = 1'b0;
    logic [3:0]        icode = 4'h0;
    logic signed [63:0] valE = '0;
    logic signed [63:0] valA = '0;
    logic [63:0]       valP = '0;
    logic              ready;
    logic              done;
    logic signed [63:0] valM;
    logic              dmem_error;

    int total = 0;
    int bad = 0;
    int n_done = 0;
    bit chk_en = 1'b0;

    memory_stage #(.MEM_WORDS(WORDS), .LATENCY(LAT)) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .icode      (icode),
        .valE       (valE),
        .valA       (valA),
        .valP       (valP),
        .ready      (ready),
        .done       (done),
        .valM       (valM),
        .dmem_error (dmem_error)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", nm, got, want, $time);
        end
    endtask

    // Reference model: tracks edge numbers of accept, commit and return to idle.
    logic [63:0] mmem [WORDS];
    int ecnt = 0;
    int done_at = -1;
    int free_at = 0;
    logic [3:0]  p_ic = '0;
    logic [63:0] p_addr = '0;
    logic [63:0] p_data = '0;
    logic        m_ready = 1'b1;
    logic        m_done = 1'b0;
    logic        m_err = 1'b0;
    logic [63:0] m_valm = '0;

    function automatic bit fault_of(input logic [3:0] ic, input logic [63:0] addr);
`ifdef MEM_ERR_CHECK_EN
        if (!(ic inside {4'h4, 4'h5, 4'h8, 4'h9, 4'hA, 4'hB})) return 1'b0;
        return (addr % 8 != 0) || ($signed(addr) < 0) || ((addr >> 3) >= WORDS);
`else
        return (ic == 4'hF) && (addr == 64'h1) && 1'b0;
`endif
    endfunction

    initial begin
        bit f;
        int w;
        for (int i = 0; i < WORDS; i++) mmem[i] = '0;
        forever begin
            @(posedge clk);
            ecnt++;
            if (reset) begin
                done_at = -1;
                free_at = ecnt;
                m_valm  = '0;
                m_err   = 1'b0;
            end else begin
                if (ecnt == done_at) begin
                    f = fault_of(p_ic, p_addr);
                    w = int'((p_addr >> 3) % WORDS);
                    if (p_ic inside {4'h4, 4'h8, 4'hA}) begin
                        if (!f) mmem[w] = p_data;
                    end else if (p_ic inside {4'h5, 4'h9, 4'hB}) begin
                        m_valm = f ? 64'h0 : mmem[w];
                    end
                    m_err = f;
                end
                if (ecnt > free_at && start) begin
                    p_ic    = icode;
                    p_addr  = (icode == 4'h9 || icode == 4'hB) ? valA : valE;
                    p_data  = (icode == 4'h8) ? valP : valA;
                    done_at = ecnt + LAT;
                    free_at = ecnt + LAT + 1;
                    m_err   = 1'b0;
                end
            end
            m_ready = (ecnt >= free_at);
            m_done  = (ecnt == done_at);
        end
    end

    // Compare process: every cycle after reset has been applied once.
    initial begin
        forever begin
            @(negedge clk);
            if (done) n_done++;
            if (chk_en) begin
                chk("ready", {63'd0, ready}, {63'd0, m_ready});
                chk("done", {63'd0, done}, {63'd0, m_done});
                chk("valM", valM, m_valm);
                chk("dmem_error", {63'd0, dmem_error}, {63'd0, m_err});
            end
        end
    end

    task automatic run_op(input logic [3:0] ic, input logic [63:0] e, input logic [63:0] a,
                          input logic [63:0] p, output logic [63:0] vm, output logic err);
        int guard = 0;
        int lat = 0;
        while (!ready && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        if (guard >= 50) chk("ready_timeout", 64'd0, 64'd1);
        icode = ic; valE = e; valA = a; valP = p; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        icode = 4'($urandom_range(0, 15));
        valE  = {$urandom, $urandom};
        valA  = {$urandom, $urandom};
        valP  = {$urandom, $urandom};
        while (!done && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        chk("done_latency", 64'(lat), 64'd2);
        vm  = valM;
        err = dmem_error;
        @(negedge clk);
    endtask

    initial begin
        logic [63:0] vm;
        logic        err;
        int          d0;
        @(posedge clk);
        chk_en = 1'b1;
        repeat (2) @(negedge clk);
        chk("rst_ready", {63'd0, ready}, 64'd1);
        chk("rst_done", {63'd0, done}, 64'd0);
        chk("rst_valM", valM, 64'd0);
        chk("rst_err", {63'd0, dmem_error}, 64'd0);
        reset = 1'b0;
        @(negedge clk);

        run_op(4'hA, 64'h100, 64'h2A, 64'h0, vm, err);
        run_op(4'hB, 64'h108, 64'h100, 64'h0, vm, err);
        chk("popq", vm, 64'h2A);

        run_op(4'h4, 64'h08, -64'sd5, 64'h0, vm, err);
        run_op(4'h5, 64'h08, 64'h0, 64'h0, vm, err);
        chk("mrmovq_neg", vm, 64'hFFFF_FFFF_FFFF_FFFB);
        run_op(4'h8, 64'h10, 64'h77, 64'h40, vm, err);
        run_op(4'h9, 64'h18, 64'h10, 64'h0, vm, err);
        chk("ret", vm, 64'h40);

        // second start during BUSY must be dropped
        d0 = n_done;
        icode = 4'h5; valE = 64'h08; start = 1'b1;
        @(negedge clk);
        icode = 4'h4; valE = 64'h30; valA = 64'd99;
        @(negedge clk);
        start = 1'b0;
        repeat (8) @(negedge clk);
        chk("ignored_done_count", 64'(n_done - d0), 64'd1);
        chk("ignored_valM", valM, 64'hFFFF_FFFF_FFFF_FFFB);
        run_op(4'h5, 64'h30, 64'h0, 64'h0, vm, err);
        chk("ignored_mem", vm, 64'h0);

        run_op(4'h4, 64'h0, 64'h55, 64'h0, vm, err);
        run_op(4'h5, 64'h800, 64'h0, 64'h0, vm, err);
`ifdef MEM_ERR_CHECK_EN
        chk("oob_err", {63'd0, err}, 64'd1);
        chk("oob_valM", vm, 64'h0);
`else
        chk("oob_err", {63'd0, err}, 64'd0);
        chk("oob_wrap", vm, 64'h55);
`endif

        // reset the cycle after an rmmovq is accepted
        d0 = n_done;
        icode = 4'h4; valE = 64'h20; valA = 64'd7; start = 1'b1;
        @(negedge clk);
        start = 1'b0; reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        repeat (5) @(negedge clk);
        chk("abort_no_done", 64'(n_done - d0), 64'd0);
        run_op(4'h5, 64'h20, 64'h0, 64'h0, vm, err);
        chk("abort_mem", vm, 64'h0);

        run_op(4'h5, 64'h08, 64'h0, 64'h0, vm, err);
        run_op(4'h1, 64'h08, 64'h30, 64'h0, vm, err);
        chk("nop_valM_hold", vm, 64'hFFFF_FFFF_FFFF_FFFB);
        run_op(4'h5, 64'h30, 64'h0, 64'h0, vm, err);
        chk("nop_no_write", vm, 64'h0);

        repeat (4) @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1);
    end

endmodule
